// File: rtl/dpot_responder_if.sv
// Pin-level SPI link between a Pmod DPOT master and the responder, plus the
// responder's status outputs.
interface dpot_responder_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              nCS;
  logic              SCLK;
  logic              MOSI;
  logic [DATA_W-1:0] wiper;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output nCS,
    output SCLK,
    output MOSI,
    input  wiper,
    input  busy,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  nCS,
    input  SCLK,
    input  MOSI,
    output wiper,
    output busy,
    output frame_done,
    output frame_err
  );

endinterface

// File: rtl/dpot_responder.sv
// SPI write-frame receiver for the Pmod DPOT link: synchronizes the pins into clk,
// shifts MSB-first frames and commits good ones to the wiper register.
module dpot_responder #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE = DATA_W'(8'h80),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              nrst,
  dpot_responder_if.slave  bus_io
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntSat  = CntW'(DATA_W + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ncs_prev_q, ncs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      wiper_q, wiper_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   close_q, close_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic ncs_s, sclk_s, mosi_s;
  logic ncs_rise, ncs_fall, sclk_rise;

  always_comb begin
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], bus_io.nCS};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus_io.SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus_io.MOSI};

    ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    sclk_s = sclk_sync_q[SYNC_STAGES-1];
    mosi_s = mosi_sync_q[SYNC_STAGES-1];

    ncs_prev_d  = ncs_s;
    sclk_prev_d = sclk_s;
    ncs_rise    = ncs_s & ~ncs_prev_q;
    ncs_fall    = ~ncs_s & ncs_prev_q;
    sclk_rise   = sclk_s & ~sclk_prev_q;

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    wiper_d = wiper_q;
    close_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Judge the frame one cycle after the close; reads only _q values, so a new
    // frame opening in this same cycle cannot disturb the commit.
    if (close_q) begin
      if (cnt_q == CntFull) begin
        wiper_d = shift_q;
        done_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          state_d = StShift;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // A clock edge coincident with the close is dropped.
        if (ncs_rise) begin
          state_d = StIdle;
          close_d = 1'b1;
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= StIdle;
      shift_q     <= '0;
      wiper_q     <= RESET_VALUE;
      cnt_q       <= '0;
      close_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ncs_prev_q  <= ncs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      wiper_q     <= wiper_d;
      cnt_q       <= cnt_d;
      close_q     <= close_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.wiper      = wiper_q;
  assign bus_io.busy       = (state_q == StShift);
  assign bus_io.frame_done = done_q;
  assign bus_io.frame_err  = err_q;

endmodule

// File: tb/tb_dpot_responder.sv
// Directed plus randomized frames against a frame-level model of the DPOT responder.
module tb_dpot_responder;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          LAT         = SYNC_STAGES + 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  dpot_responder_if #(.DATA_W(DATA_W)) bus ();

  dpot_responder #(
    .DATA_W      (DATA_W),
    .RESET_VALUE (8'h80),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Output activity observed by the bench.
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int wiper_jump = 0;
  logic [DATA_W-1:0] wiper_prev;

  // Frame-level model.
  logic [DATA_W-1:0] exp_wiper;
  int exp_done = 0;
  int exp_err = 0;

  always @(posedge clk) begin
    #1;
    if (bus.frame_done) done_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.frame_done && bus.frame_err) both_cnt++;
    if (bus.busy) busy_cnt++;
    if (nrst && (bus.wiper !== wiper_prev) && !bus.frame_done) wiper_jump++;
    wiper_prev = bus.wiper;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model(input logic [15:0] v, input int n);
    if (n == DATA_W) begin
      exp_wiper = v[DATA_W-1:0];
      exp_done++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic open_frame();
    @(negedge clk);
    bus.SCLK = 1'b0;
    bus.nCS  = 1'b0;
    cycles(4);
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      bus.SCLK = 1'b0;
      bus.MOSI = v[i];
      cycles(half);
      bus.SCLK = 1'b1;
      cycles(half);
    end
  endtask

  // Closes the frame and returns the pulse latency in clk edges (0 if no pulse
  // arrives) and the wiper value in the cycle before the pulse.
  task automatic close_wait(input bit sclk_with_ncs, output int lat,
                            output logic [DATA_W-1:0] wb);
    bus.SCLK = 1'b0;
    cycles(2);
    if (sclk_with_ncs) bus.SCLK = 1'b1;
    bus.nCS = 1'b1;
    lat = 0;
    wb  = bus.wiper;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done || bus.frame_err) begin
        lat = k;
        break;
      end
      wb = bus.wiper;
    end
    @(negedge clk);
    bus.SCLK = 1'b0;
    cycles(2);
  endtask

  task automatic check_state(input string tag);
    check({tag, " wiper"}, 32'(bus.wiper), 32'(exp_wiper));
    check({tag, " done_cnt"}, done_cnt, exp_done);
    check({tag, " err_cnt"}, err_cnt, exp_err);
    check({tag, " both"}, both_cnt, 0);
    check({tag, " wiper_jump"}, wiper_jump, 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
  endtask

  task automatic do_frame(input string tag, input logic [15:0] v, input int n,
                          input int half, input bit sclk_with_ncs);
    int lat;
    logic [DATA_W-1:0] wb;
    open_frame();
    check({tag, " busy open"}, 32'(bus.busy), 1);
    shift_bits(v, n, half);
    close_wait(sclk_with_ncs, lat, wb);
    check({tag, " wiper before pulse"}, 32'(wb), 32'(exp_wiper));
    model(v, n);
    check({tag, " latency"}, lat, LAT);
    check_state(tag);
  endtask

  initial begin
    int lat;
    int d0, e0, b0;
    logic [DATA_W-1:0] wb;
    logic [15:0] rv;
    int rn, rh;

    bus.nCS  = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    exp_wiper = 8'h80;
    cycles(3);
    check("reset wiper", 32'(bus.wiper), 32'h80);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.frame_done), 0);
    check("reset err", 32'(bus.frame_err), 0);
    nrst = 1'b1;
    cycles(3);

    do_frame("t1 a5", 16'h00A5, 8, 2, 1'b0);
    do_frame("t2 ce", 16'h00CE, 8, 3, 1'b0);
    do_frame("t3 7bit", 16'h0055, 7, 2, 1'b0);
    do_frame("t4 9bit", 16'h01F0, 9, 2, 1'b0);

    // SCLK/MOSI activity with nCS high must be ignored.
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.SCLK = ~bus.SCLK;
      bus.MOSI = 1'($urandom);
      cycles(1);
    end
    bus.SCLK = 1'b0;
    cycles(6);
    check("t5 busy cycles", busy_cnt - b0, 0);
    check("t5 done", done_cnt - d0, 0);
    check("t5 err", err_cnt - e0, 0);
    check("t5 wiper", 32'(bus.wiper), 32'(exp_wiper));

    // Reset after four bits drops the frame silently.
    open_frame();
    shift_bits(16'h000B, 4, 2);
    nrst = 1'b0;
    bus.nCS  = 1'b1;
    bus.SCLK = 1'b0;
    cycles(1);
    check("t6 wiper in reset", 32'(bus.wiper), 32'h80);
    check("t6 busy in reset", 32'(bus.busy), 0);
    cycles(2);
    nrst = 1'b1;
    exp_wiper = 8'h80;
    cycles(10);
    check_state("t6 after reset");
    do_frame("t6 3c", 16'h003C, 8, 2, 1'b0);

    // SCLK rise and nCS rise seen together: the extra rise is discarded.
    do_frame("simul", 16'h0096, 8, 2, 1'b1);

    // nCS high for one clk: new frame opens on the cycle the previous one commits.
    open_frame();
    shift_bits(16'h005A, 8, 2);
    bus.SCLK = 1'b0;
    cycles(2);
    bus.nCS = 1'b1;
    cycles(1);
    bus.nCS = 1'b0;
    model(16'h005A, 8);
    cycles(6);
    check("b2b first done", done_cnt, exp_done);
    check("b2b first wiper", 32'(bus.wiper), 32'h5A);
    check("b2b second busy", 32'(bus.busy), 1);
    shift_bits(16'h00C3, 8, 2);
    close_wait(1'b0, lat, wb);
    model(16'h00C3, 8);
    check("b2b second latency", lat, LAT);
    check_state("b2b second");

    for (int i = 0; i < 12; i++) begin
      rn = $urandom_range(10, 6);
      rh = $urandom_range(3, 2);
      rv = 16'($urandom);
      do_frame($sformatf("rand%0d n%0d", i, rn), rv, rn, rh, 1'b0);
    end

    // Master-style traffic at SCLK = clk/4.
    do_frame("loop a5", 16'h00A5, 8, 2, 1'b0);
    do_frame("loop ce", 16'h00CE, 8, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
